awb_grayworld: RTL

- Gray-world auto-white-balance stage that sits directly downstream of the Bayer demosaic.
- Consumes the demosaic's RGB pixel stream (R, G, B, valid, done) and applies per-channel R and B gains to every pixel; G passes through unchanged.
- Accumulates per-frame channel sums and, after each frame, computes new gains with a sequential divider.
- Output feeds the colour pipeline / display path with the same valid/done semantics.

---
 rtl/awb_pkg.sv | 21 ++
 rtl/awb_divider.sv | 92 +++++++++
 rtl/awb_grayworld.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/awb_pkg.sv
// rtl/awb_pkg.sv - shared constants for the gray-world auto-white-balance stage
//
// Purpose: unity gain, output rounding constant and FSM state encodings
//          shared by awb_grayworld and awb_divider.
// Ports:   none (package).

package awb_pkg;

  // Gain value that leaves a channel untouched (1.0 in Q2.8).
  localparam int UNITY_GAIN = 256;

  // Half an LSB of the Q2.8 product, added before truncating back to 8 bits.
  localparam int ROUND_HALF = 128;

  // Gain-update sequencer states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIV_R  = 2'd1;
  localparam logic [1:0] ST_DIV_B  = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

endpackage

// File: rtl/awb_divider.sv
// rtl/awb_divider.sv - sequential restoring divider with saturating quotient
//
// Purpose: unsigned num / den, one quotient bit per cycle (NUM_W cycles after
//          the load cycle). The quotient saturates to all-ones at Q_W bits.
//          A zero divisor skips the iteration and returns ZERO_Q one cycle
//          after start.
// Ports:   clk, reset  - clock, asynchronous active-high reset
//          start       - load num/den and begin (ignored while busy)
//          num, den    - dividend (NUM_W) and divisor (DEN_W)
//          busy        - iteration in progress
//          done        - one-cycle pulse, quot valid from this cycle on
//          quot        - saturated quotient, held until the next result

module awb_divider
  import awb_pkg::*;
#(
  parameter int              NUM_W  = 40,
  parameter int              DEN_W  = 32,
  parameter int              Q_W    = 10,
  parameter logic [Q_W-1:0]  ZERO_Q = Q_W'(UNITY_GAIN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quot
);

  localparam int             CNT_W = $clog2(NUM_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_W - 1);

  logic [NUM_W-1:0] num_sh;
  logic [NUM_W-1:0] q_sh;
  logic [NUM_W-1:0] q_next;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W-1:0] rem;
  logic [DEN_W:0]   rem_sh;
  logic [DEN_W-1:0] diff;
  logic             ge;
  logic [CNT_W-1:0] cnt;

  // The remainder is always < den, so the shifted remainder needs one extra
  // bit for the compare while the difference fits back in DEN_W bits.
  always_comb begin
    rem_sh = {rem, num_sh[NUM_W-1]};
    ge     = (rem_sh >= {1'b0, den_q});
    diff   = rem_sh[DEN_W-1:0] - den_q;
    q_next = {q_sh[NUM_W-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      quot   <= '0;
      num_sh <= '0;
      q_sh   <= '0;
      den_q  <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        if (den == '0) begin
          quot <= ZERO_Q;
          done <= 1'b1;
        end else begin
          busy   <= 1'b1;
          cnt    <= '0;
          num_sh <= num;
          den_q  <= den;
          rem    <= '0;
          q_sh   <= '0;
        end
      end else if (busy) begin
        num_sh <= num_sh << 1;
        rem    <= ge ? diff : rem_sh[DEN_W-1:0];
        q_sh   <= q_next;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          quot <= (|q_next[NUM_W-1:Q_W]) ? '1 : q_next[Q_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/awb_grayworld.sv
// rtl/awb_grayworld.sv - gray-world auto-white-balance stage
//
// Purpose: applies Q2.8 R/B gains to the demosaiced RGB stream (2-cycle
//          latency, no stalls), accumulates per-frame channel sums and after
//          each frame computes gainR = (sumG<<FRAC)/sumR and
//          gainB = (sumG<<FRAC)/sumB with one shared sequential divider.
//          Results become pending, and pending gains are committed at each
//          iDone, so frame N statistics apply from frame N+2.
// Ports:   clk, reset      - clock, asynchronous active-high reset
//          iR, iG, iB      - input pixel; iValid qualifier; iDone last pixel
//          iAwbEn          - 1 apply gains, 0 force unity (stats still run)
//          oR, oG, oB      - balanced pixel; oValid/oDone = inputs delayed 2
//          oGainR, oGainB  - active gains (Q2.8)
//          oBusy           - gain computation running
//          oDropped        - sticky, a frame ended while computation was busy

module awb_grayworld
  import awb_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int FRAC   = 8,
  parameter int GAIN_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        iR,
  input  logic [7:0]        iG,
  input  logic [7:0]        iB,
  input  logic              iValid,
  input  logic              iDone,
  input  logic              iAwbEn,
  output logic [7:0]        oR,
  output logic [7:0]        oG,
  output logic [7:0]        oB,
  output logic              oValid,
  output logic              oDone,
  output logic [GAIN_W-1:0] oGainR,
  output logic [GAIN_W-1:0] oGainB,
  output logic              oBusy,
  output logic              oDropped
);

  localparam int                PROD_W = 8 + GAIN_W;
  localparam int                NUM_W  = ACC_W + FRAC;
  localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(UNITY_GAIN);

  logic [1:0]        state;
  logic [GAIN_W-1:0] act_r, act_b, pend_r, pend_b, res_r;
  logic [GAIN_W-1:0] g_r, g_b;
  logic [ACC_W-1:0]  sum_r, sum_g, sum_b;
  logic [ACC_W-1:0]  nxt_r, nxt_g, nxt_b;
  logic [ACC_W-1:0]  snap_g, snap_b;
  logic [PROD_W-1:0] p1_r, p1_b;
  logic [7:0]        p1_g;
  logic              v1, d1;

  logic              div_start, div_busy, div_done;
  logic [NUM_W-1:0]  div_num;
  logic [ACC_W-1:0]  div_den;
  logic [GAIN_W-1:0] div_quot;

  function automatic logic [7:0] round_sat(input logic [PROD_W-1:0] p);
    logic [PROD_W:0] s;
    s = ({1'b0, p} + (PROD_W + 1)'(ROUND_HALF)) >> FRAC;
    return (|s[PROD_W:8]) ? 8'hFF : s[7:0];
  endfunction

  assign g_r    = iAwbEn ? act_r : UNITY;
  assign g_b    = iAwbEn ? act_b : UNITY;
  assign oGainR = act_r;
  assign oGainB = act_b;
  assign oBusy  = (state == ST_DIV_R) || (state == ST_DIV_B);

  // Running sums including the current pixel; this is also the snapshot
  // value on iDone, since that pixel belongs to the ending frame.
  always_comb begin
    nxt_r = sum_r + (iValid ? ACC_W'(iR) : '0);
    nxt_g = sum_g + (iValid ? ACC_W'(iG) : '0);
    nxt_b = sum_b + (iValid ? ACC_W'(iB) : '0);
  end

  // The R division is started straight from the live sums in the iDone
  // cycle; the B division reuses the latched snapshot once R finishes.
  always_comb begin
    if (state == ST_IDLE) begin
      div_start = iDone;
      div_num   = {nxt_g, {FRAC{1'b0}}};
      div_den   = nxt_r;
    end else begin
      div_start = (state == ST_DIV_R) && div_done;
      div_num   = {snap_g, {FRAC{1'b0}}};
      div_den   = snap_b;
    end
    div_start = div_start && !div_busy;
  end

  awb_divider #(
    .NUM_W  (NUM_W),
    .DEN_W  (ACC_W),
    .Q_W    (GAIN_W),
    .ZERO_Q (UNITY)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  // Statistics, gain commit and update sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      sum_r    <= '0;
      sum_g    <= '0;
      sum_b    <= '0;
      snap_g   <= '0;
      snap_b   <= '0;
      res_r    <= UNITY;
      pend_r   <= UNITY;
      pend_b   <= UNITY;
      act_r    <= UNITY;
      act_b    <= UNITY;
      oDropped <= 1'b0;
    end else begin
      if (iDone) begin
        sum_r <= '0;
        sum_g <= '0;
        sum_b <= '0;
        act_r <= pend_r;
        act_b <= pend_b;
        if (state != ST_IDLE) oDropped <= 1'b1;
      end else if (iValid) begin
        sum_r <= nxt_r;
        sum_g <= nxt_g;
        sum_b <= nxt_b;
      end

      case (state)
        ST_IDLE: begin
          if (iDone) begin
            snap_g <= nxt_g;
            snap_b <= nxt_b;
            state  <= ST_DIV_R;
          end
        end
        ST_DIV_R: begin
          if (div_done) begin
            res_r <= div_quot;
            state <= ST_DIV_B;
          end
        end
        ST_DIV_B: begin
          if (div_done) state <= ST_UPDATE;
        end
        default: begin
          // The divider holds the B quotient until its next start.
          pend_r <= res_r;
          pend_b <= div_quot;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Two-stage pixel pipeline: multiply, then round and saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_r   <= '0;
      p1_g   <= '0;
      p1_b   <= '0;
      v1     <= 1'b0;
      d1     <= 1'b0;
      oR     <= '0;
      oG     <= '0;
      oB     <= '0;
      oValid <= 1'b0;
      oDone  <= 1'b0;
    end else begin
      v1     <= iValid;
      d1     <= iDone;
      oValid <= v1;
      oDone  <= d1;
      if (iValid) begin
        p1_r <= PROD_W'(iR) * PROD_W'(g_r);
        p1_b <= PROD_W'(iB) * PROD_W'(g_b);
        p1_g <= iG;
      end
      if (v1) begin
        oR <= round_sat(p1_r);
        oG <= p1_g;
        oB <= round_sat(p1_b);
      end
    end
  end

endmodule
